// File: rtl/sau_mul_sequencer.sv
// sau_mul_sequencer: digit-serial signed multiplier controller.
// One shift-add unit (sau) supplies sample*1..sample*8. The sequencer walks
// the coefficient magnitude in base-8 digits, MSB first, and accumulates one
// selected multiple per cycle. It applies the coefficient sign when the last
// digit is added.

// sau: combinational shift-add unit; out[k] = x*(k+1) for k = 0..7.
module sau #(
   parameter int WIDTH = 20
) (
   input  logic signed [WIDTH-1:0] x,
   output logic signed [WIDTH+2:0] out [8]
);

   logic signed [WIDTH+2:0] x1, x2, x4, x8;

   // Build every multiple from shifted copies of the sample and one add or subtract each.
   always_comb begin
      x1     = {{3{x[WIDTH-1]}}, x};
      x2     = x1 <<< 1;
      x4     = x1 <<< 2;
      x8     = x1 <<< 3;
      out[0] = x1;
      out[1] = x2;
      out[2] = x2 + x1;
      out[3] = x4;
      out[4] = x4 + x1;
      out[5] = x4 + x2;
      out[6] = x8 - x1;
      out[7] = x8;
   end

endmodule

module sau_mul_sequencer #(
   parameter int WIDTH  = 20,
   parameter int COEF_W = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic signed [WIDTH-1:0]          in_sample,
   input  logic signed [COEF_W-1:0]         in_coef,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic signed [WIDTH+COEF_W-1:0]   out_data
);

   localparam int NDIG  = (COEF_W + 2) / 3;
   localparam int OUT_W = WIDTH + COEF_W;
   localparam int ACC_W = OUT_W + 1;
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int TW    = WIDTH + 3;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                   state, nstate;
   logic signed [WIDTH-1:0]  smp_p0;
   logic [COEF_W-1:0]        mag_p0;
   logic                     neg_p0;
   logic signed [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]         cnt;

   logic signed [TW-1:0]     sau_out [8];
   logic [3*NDIG-1:0]        mag_ext;
   logic [3*NDIG-1:0]        mag_sh;
   logic [2:0]               dig;
   logic [2:0]               sel;
   logic signed [ACC_W-1:0]  term;
   logic signed [ACC_W-1:0]  acc_nxt;
   logic [COEF_W-1:0]        mag_in;

   // The product fits OUT_W even after negation, so dropping the top
   // accumulator bit only removes a copy of the sign.
   function automatic logic signed [OUT_W-1:0] sign_trunc(input logic signed [ACC_W-1:0] v,
                                                          input logic neg);
      logic signed [ACC_W-1:0] r;
      r = neg ? -v : v;
      return r[OUT_W-1:0];
   endfunction

   sau #(.WIDTH(WIDTH)) u_sau (
      .x   (smp_p0),
      .out (sau_out)
   );

   // Digit select and shift-accumulate; a zero digit contributes nothing.
   always_comb begin
      mag_ext = (3*NDIG)'(mag_p0);
      mag_sh  = mag_ext >> (3 * cnt);
      dig     = mag_sh[2:0];
      sel     = dig - 3'd1;
      term    = '0;
      if (dig != 3'd0)
         term = {{(ACC_W-TW){sau_out[sel][TW-1]}}, sau_out[sel]};
      acc_nxt = (acc <<< 3) + term;
      mag_in  = in_coef[COEF_W-1] ? $unsigned(-in_coef) : $unsigned(in_coef);
   end

   assign in_ready  = rst_n && (state == IDLE);
   assign out_valid = (state == DONE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   // Next-state logic.
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (in_valid)         nstate = CALC;
         CALC:    if (cnt == '0)        nstate = DONE;
         DONE:    if (out_ready)        nstate = IDLE;
         default:                       nstate = IDLE;
      endcase
   end

   // Operand capture, digit accumulation and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp_p0   <= '0;
         mag_p0   <= '0;
         neg_p0   <= 1'b0;
         acc      <= '0;
         cnt      <= '0;
         out_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  smp_p0 <= in_sample;
                  mag_p0 <= mag_in;
                  neg_p0 <= in_coef[COEF_W-1];
                  acc    <= '0;
                  cnt    <= CNT_W'(NDIG - 1);
               end
            end
            CALC: begin
               acc <= acc_nxt;
               if (cnt == '0) out_data <= sign_trunc(acc_nxt, neg_p0);
               else           cnt      <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sau_mul_sequencer.sv
// Directed bench for sau_mul_sequencer: reset, signed products, extremes,
// backpressure, streaming throughput and reset during a calculation.
module tb_sau_mul_sequencer;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic signed [19:0]  in_sample;
   logic signed [7:0]   in_coef;
   logic                out_valid;
   logic                out_ready;
   logic signed [27:0]  out_data;

   int n_cmp = 0;
   int n_err = 0;

   sau_mul_sequencer #(.WIDTH(20), .COEF_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sample (in_sample),
      .in_coef   (in_coef),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction with out_ready high; checks latency and product.
   task automatic run(input logic signed [19:0] s, input logic signed [7:0] c,
                      input logic signed [63:0] exp, input string tag);
      int w;
      w = 0;
      in_sample = s;
      in_coef   = c;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      check({tag, "_rdy"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check({tag, "_early"}, out_valid, 0);
      tick();
      check({tag, "_vld"}, out_valid, 1);
      check(tag, out_data, exp);
      tick();
      check({tag, "_idle"}, in_ready, 1);
   endtask

   initial begin
      logic signed [27:0] held;
      logic signed [19:0] s;
      logic signed [7:0]  c;
      logic [31:0]        r;
      logic               take;
      logic               stale;
      logic signed [63:0] q[$];
      int                 cyc, last_acc, got;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sample = '0;
      in_coef   = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 1);
      tick();

      // Basic multiply held in DONE to exercise backpressure.
      in_sample = 20'sd1000;
      in_coef   = 8'sd83;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check("basic_busy", in_ready, 0);
      tick();
      tick();
      check("basic_early", out_valid, 0);
      tick();
      check("basic_vld", out_valid, 1);
      check("basic_prod", out_data, 83000);
      held = out_data;
      for (int i = 0; i < 5; i++) begin
         in_valid  = i[0];
         in_sample = 20'sd77;
         in_coef   = 8'sd5;
         tick();
         check("bp_data", out_data, held);
         check("bp_vld", out_valid, 1);
         check("bp_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_vld", out_valid, 0);
      check("bp_release_rdy", in_ready, 1);

      run(-20'sd5, -8'sd90, 450, "neg_neg");
      run(20'sd12345, 8'sd0, 0, "coef_zero");
      run(-20'sd1, 8'sd36, -36, "neg_pos");
      run(-20'sd524288, -8'sd128, 67108864, "min_min");
      run(20'sd524287, 8'sd127, 66584449, "max_max");
      run(20'sd7, -8'sd64, -448, "pos_neg");

      // Streaming with in_valid held high and random operands every cycle.
      cyc      = 0;
      last_acc = -1;
      got      = 0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while (got < 20 && cyc < 300) begin
         r = $urandom;
         s = r[19:0];
         c = r[27:20];
         in_sample = s;
         in_coef   = c;
         take = in_ready;
         tick();
         cyc++;
         if (take) begin
            q.push_back(64'(s) * 64'(c));
            if (last_acc >= 0) check("stream_gap", cyc - last_acc, 5);
            last_acc = cyc;
         end
         if (out_valid) begin
            if (q.size() > 0) check("stream_prod", out_data, q.pop_front());
            else              check("stream_extra", out_valid, 0);
            got++;
         end
      end
      in_valid = 1'b0;
      check("stream_count", got, 20);
      tick();

      // Known nonzero result left in out_data before the mid-CALC reset.
      run(20'sd9, 8'sd11, 99, "pre_reset");
      in_sample = 20'sd50;
      in_coef   = 8'sd7;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_vld", out_valid, 0);
      check("midrst_data", out_data, 0);
      check("midrst_rdy", in_ready, 0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("midrst_release_rdy", in_ready, 1);
      stale = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid || !in_ready) stale = 1'b1;
      end
      check("midrst_no_stale", stale, 0);
      run(20'sd100, -8'sd3, -300, "after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
